smem_row_receiver: RTL and testbench
====================================

# smem_row_receiver

Consumes the 32-bit SMEM-write AXI stream produced by the SMEM writer stage. Each frame is one row-index beat (TUSER=1) followed by 4·DW/32 data beats, with TLAST on the final data beat. The block checks the framing and reassembles the data beats into four DW-bit row segments. It then presents the completed row to the SMEM write port through a valid/ready handshake and reports malformed frames.

## Interface
- DW, 512: segment width in bits; multiple of 32. Derived: EPS = DW/32 entries per segment, ENTRIES = 4·EPS (64 at default).
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- axis_in_tdata  in  32  row index (header beat) or entry value (data beat)
- axis_in_tuser  in  1  1 = header beat
- axis_in_tlast  in  1  last data beat of the frame
- axis_in_tvalid  in  1  beat valid
- axis_in_tready  out  1  beat accepted when tvalid & tready
- row_index  out  32  captured header value
- row_data3..row_data0  out  DW each  reassembled segments
- row_valid  out  1  row complete, outputs stable
- row_ready  in  1  SMEM port accepts the row
- frame_err  out  1  one-cycle pulse per framing error
- err_count  out  16  saturating framing-error count

## Operation
- States: IDLE, COLLECT, DELIVER.
- **IDLE**
  - tready=1.
  - Header beat: capture tdata into row_index, clear entry counter (log2(ENTRIES) bits), go to COLLECT.
  - Non-header beat: dropped, frame_err pulses.
- **COLLECT**
  - tready=1.
  - Entry k (counter value) is written to row_data[k/EPS][(k%EPS)·32 +: 32]. Entry 0 lands in row_data0 bits [31:0]; entry 63 lands in row_data3 bits [511:480].
  - Data beat, k<ENTRIES-1, tlast=0: store, increment k.
  - Data beat, k=ENTRIES-1, tlast=1: store, go to DELIVER.
  - Data beat with tlast=1 and k<ENTRIES-1 (short frame): frame_err, discard the row, go to IDLE.
  - Data beat with k=ENTRIES-1 and tlast=0 (long frame): frame_err, discard the row, go to IDLE. Subsequent non-header beats are dropped as IDLE errors.
  - Header beat (unexpected restart): frame_err, recapture row_index, k=0, stay in COLLECT.
- **DELIVER**
  - tready=0, row_valid=1.
  - On row_ready: go to IDLE.
- row_index and row_data are only modified in IDLE/COLLECT. They are held constant while row_valid=1.
- A discarded row never asserts row_valid.

## Timing
- **Reset values:** state IDLE, tready=0 while resetn=0 (1 in IDLE thereafter), row_valid=0, frame_err=0, err_count=0, row_index=0, row_data*=0.
- tready is combinational from state and resetn only. It never depends on tvalid.
- row_valid rises the cycle after the final data beat is accepted.
- **Deliver handshake:** row_valid & row_ready on cycle N gives row_valid=0 and tready=1 on cycle N+1. row_valid never drops without row_ready.
- **Throughput:** minimum 1 + ENTRIES + 1 cycles per row (66 at default) with row_ready tied high.
- frame_err is registered, high the cycle after the offending beat is accepted.
- Reset mid-frame or during DELIVER: partial or pending row discarded, no error counted.

## Configuration
- SMEM_RX_ERR_CNT_EN defined: err_count increments on every frame_err pulse and saturates at 0xFFFF. It clears only on reset.
- SMEM_RX_ERR_CNT_EN undefined: counter logic is not built and err_count is tied to 0. frame_err behaviour is unchanged.

## Structure
- Shared package smem_pkg:
  - SMEM_SEGMENTS=4, SMEM_ENTRY_W=32.
  - rx-state enum {IDLE, COLLECT, DELIVER}.
  - Function entries_per_segment(DW).
- One sub-module is natural: smem_rx_err_counter, the saturating 16-bit counter, instantiated only under the macro.
- Entry storage is a single 4·DW-bit register with indexed 32-bit write enables. No FIFO.

## Test plan
- Good frame: header 0x0000_0123 then entries 0x1000+k, k=0..63, row_ready=1 -> row_valid one cycle after beat 63; row_index=0x123; row_data0[31:0]=0x1000; row_data3[511:480]=0x103F; frame_err never asserts.
- Backpressure: row_ready held low 10 cycles -> row_valid and data stable, tready=0 throughout, next header accepted the cycle after row_ready.
- Short frame: tlast on entry 40 -> frame_err one pulse, no row_valid; a following good frame with row_index 0x7 delivers correctly.
- Restart: header 0x5, 20 entries, header 0x9, 64 entries+tlast -> one frame_err, single row delivered with row_index=0x9.
- Stray beats in IDLE: 3 data beats without header -> 3 frame_err pulses; err_count=3 with the macro, 0 without.
- Reset asserted at entry 30: tready=0 and row_valid=0 during reset; afterwards a full frame delivers, err_count unchanged.

Source files
------------

// File: rtl/smem_pkg.sv
// Shared SMEM definitions: segment geometry, receiver state encoding and width helpers.
package smem_pkg;

  localparam int unsigned SMEM_SEGMENTS  = 4;
  localparam int unsigned SMEM_ENTRY_W   = 32;
  localparam int unsigned SMEM_ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DELIVER = 2'd2
  } rx_state_e;

  function automatic int unsigned entries_per_segment(input int unsigned dw);
    return dw / SMEM_ENTRY_W;
  endfunction

endpackage

// File: rtl/smem_rx_err_counter.sv
// Saturating framing-error counter; cleared only by reset.
module smem_rx_err_counter
  import smem_pkg::*;
(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      inc,
  output logic [SMEM_ERR_CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + SMEM_ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/smem_row_receiver.sv
// Reassembles a framed 32-bit SMEM-write stream into a 4-segment row and hands it to the SMEM port.
// Build option: define SMEM_RX_ERR_CNT_EN to include the saturating framing-error counter.
module smem_row_receiver
  import smem_pkg::*;
#(
  parameter int unsigned DW = 512
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [SMEM_ENTRY_W-1:0]   axis_in_tdata,
  input  logic                      axis_in_tuser,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [31:0]               row_index,
  output logic [DW-1:0]             row_data3,
  output logic [DW-1:0]             row_data2,
  output logic [DW-1:0]             row_data1,
  output logic [DW-1:0]             row_data0,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic                      frame_err,
  output logic [SMEM_ERR_CNT_W-1:0] err_count
);

  localparam int unsigned EPS     = entries_per_segment(DW);
  localparam int unsigned ENTRIES = SMEM_SEGMENTS * EPS;
  localparam int unsigned CNT_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned ROW_W   = SMEM_SEGMENTS * DW;

  rx_state_e            state;
  rx_state_e            state_next;
  logic [CNT_W-1:0]     entry_idx;
  logic [ROW_W-1:0]     row_buf;
  logic                 accept;
  logic                 last_slot;
  logic                 hdr_cap;
  logic                 entry_we;
  logic                 err_c;

  assign accept    = axis_in_tvalid & axis_in_tready;
  assign last_slot = (entry_idx == CNT_W'(ENTRIES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; any framing violation abandons the row
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && axis_in_tuser) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && !axis_in_tuser) begin
          if (last_slot) begin
            state_next = axis_in_tlast ? DELIVER : IDLE;
          end else if (axis_in_tlast) begin
            state_next = IDLE;
          end
        end
      end
      DELIVER: begin
        if (row_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    axis_in_tready = resetn & (state != DELIVER);
    row_valid      = (state == DELIVER);
    hdr_cap        = 1'b0;
    entry_we       = 1'b0;
    err_c          = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          hdr_cap = axis_in_tuser;
          err_c   = ~axis_in_tuser;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (axis_in_tuser) begin
            hdr_cap = 1'b1;
            err_c   = 1'b1;
          end else if (last_slot == axis_in_tlast) begin
            entry_we = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Header capture, entry counter and row storage with per-entry write enables
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_index <= '0;
      entry_idx <= '0;
      row_buf   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_c;
      if (hdr_cap) begin
        row_index <= axis_in_tdata;
        entry_idx <= '0;
      end else if (entry_we) begin
        entry_idx <= entry_idx + CNT_W'(1);
      end
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (entry_we && (entry_idx == CNT_W'(i))) begin
          row_buf[i*SMEM_ENTRY_W +: SMEM_ENTRY_W] <= axis_in_tdata;
        end
      end
    end
  end

  assign row_data0 = row_buf[0*DW +: DW];
  assign row_data1 = row_buf[1*DW +: DW];
  assign row_data2 = row_buf[2*DW +: DW];
  assign row_data3 = row_buf[3*DW +: DW];

`ifdef SMEM_RX_ERR_CNT_EN
  smem_rx_err_counter u_err_counter (
    .clk    (clk),
    .resetn (resetn),
    .inc    (frame_err),
    .count  (err_count)
  );
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_smem_row_receiver.sv
// Directed and randomized bench for smem_row_receiver against a queue-based frame model.
module tb_smem_row_receiver;

  localparam int unsigned DW      = 512;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned ROW_W   = 4 * DW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [31:0]   axis_in_tdata;
  logic          axis_in_tuser;
  logic          axis_in_tlast;
  logic          axis_in_tvalid;
  logic          axis_in_tready;
  logic [31:0]   row_index;
  logic [DW-1:0] row_data3, row_data2, row_data1, row_data0;
  logic          row_valid;
  logic          row_ready;
  logic          frame_err;
  logic [15:0]   err_count;

  always #5 clk = ~clk;

  smem_row_receiver #(.DW(DW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .axis_in_tdata  (axis_in_tdata),
    .axis_in_tuser  (axis_in_tuser),
    .axis_in_tlast  (axis_in_tlast),
    .axis_in_tvalid (axis_in_tvalid),
    .axis_in_tready (axis_in_tready),
    .row_index      (row_index),
    .row_data3      (row_data3),
    .row_data2      (row_data2),
    .row_data1      (row_data1),
    .row_data0      (row_data0),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .frame_err      (frame_err),
    .err_count      (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Frame model: a frame is open after a header; it completes when exactly ENTRIES entries end in tlast.
  bit              m_in;
  logic [31:0]     m_idx;
  logic [31:0]     m_q[$];
  int              m_err;
  bit              m_pending;
  logic [31:0]     exp_index;
  logic [ROW_W-1:0] exp_row;
  bit              gap_en;
  time             t_hdr;

  function automatic int exp_cnt(input int c);
`ifdef SMEM_RX_ERR_CNT_EN
    return (c > 65535) ? 65535 : c;
`else
    return 0 * c;
`endif
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_row(input string tag);
    check({tag, "_index"}, DW'(row_index), DW'(exp_index));
    check({tag, "_d0"}, row_data0, exp_row[0*DW +: DW]);
    check({tag, "_d1"}, row_data1, exp_row[1*DW +: DW]);
    check({tag, "_d2"}, row_data2, exp_row[2*DW +: DW]);
    check({tag, "_d3"}, row_data3, exp_row[3*DW +: DW]);
  endtask

  task automatic gap();
    axis_in_tvalid = 1'b0;
    axis_in_tdata  = $urandom;
    axis_in_tuser  = 1'($urandom);
    axis_in_tlast  = 1'($urandom);
    @(posedge clk); #1;
    check("err_pulse_len", DW'(frame_err), DW'(0));
  endtask

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    int waits;
    int cnt_before;
    bit err;
    bit done;
    if (gap_en && ($urandom_range(3) == 0)) gap();
    axis_in_tdata  = d;
    axis_in_tuser  = u;
    axis_in_tlast  = l;
    axis_in_tvalid = 1'b1;
    waits = 0;
    while (axis_in_tready !== 1'b1) begin
      if (waits == 100) begin
        $display("FAIL tready_timeout: tready=%b after %0d cycles, required 1", axis_in_tready, waits);
        $fatal(1, "receiver stopped accepting beats");
      end
      @(posedge clk); #1;
      waits++;
    end
    @(posedge clk);
    if (u) t_hdr = $time;
    #1;
    axis_in_tvalid = 1'b0;

    cnt_before = m_err;
    err  = 1'b0;
    done = 1'b0;
    if (u) begin
      err   = m_in;
      m_in  = 1'b1;
      m_idx = d;
      m_q.delete();
    end else if (!m_in) begin
      err = 1'b1;
    end else begin
      m_q.push_back(d);
      if (l) begin
        if (m_q.size() == ENTRIES) done = 1'b1;
        else err = 1'b1;
        m_in = 1'b0;
      end else if (m_q.size() == ENTRIES) begin
        err  = 1'b1;
        m_in = 1'b0;
      end
    end
    if (err) m_err++;

    check("frame_err", DW'(frame_err), DW'(err));
    check("row_valid", DW'(row_valid), DW'(done));
    check("err_count", DW'(err_count), DW'(exp_cnt(cnt_before)));
    if (done) begin
      m_pending = 1'b1;
      exp_index = m_idx;
      for (int e = 0; e < ENTRIES; e++) exp_row[e*32 +: 32] = m_q[e];
      check_row("row");
      check("deliver_tready", DW'(axis_in_tready), DW'(0));
    end
  endtask

  task automatic send_row(input logic [31:0] idx, input int n, input bit tl, input bit rnd,
                          input logic [31:0] base);
    logic [31:0] d;
    send_beat(idx, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      d = rnd ? $urandom : base + 32'(k);
      send_beat(d, 1'b0, tl && (k == n - 1));
    end
  endtask

  // Hold row_ready low for n cycles while offering a header that must not be taken, then release.
  task automatic deliver(input int n);
    for (int i = 0; i < n; i++) begin
      row_ready      = 1'b0;
      axis_in_tvalid = 1'b1;
      axis_in_tuser  = 1'b1;
      axis_in_tlast  = 1'b0;
      axis_in_tdata  = $urandom;
      @(posedge clk); #1;
      check("hold_valid", DW'(row_valid), DW'(1));
      check("hold_tready", DW'(axis_in_tready), DW'(0));
      check_row("hold");
    end
    row_ready = 1'b1;
    @(posedge clk); #1;
    axis_in_tvalid = 1'b0;
    row_ready      = 1'b0;
    check("release_valid", DW'(row_valid), DW'(0));
    check("release_tready", DW'(axis_in_tready), DW'(1));
    check("release_index", DW'(row_index), DW'(exp_index));
    m_pending = 1'b0;
  endtask

  task automatic do_reset();
    resetn         = 1'b0;
    axis_in_tvalid = 1'b0;
    #1;
    check("rst_tready", DW'(axis_in_tready), DW'(0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", DW'(row_valid), DW'(0));
    check("rst_tready_hold", DW'(axis_in_tready), DW'(0));
    check("rst_frame_err", DW'(frame_err), DW'(0));
    check("rst_err_count", DW'(err_count), DW'(0));
    check("rst_index", DW'(row_index), DW'(0));
    check("rst_d0", row_data0, DW'(0));
    check("rst_d3", row_data3, DW'(0));
    resetn = 1'b1;
    m_in = 1'b0;
    m_q.delete();
    m_err = 0;
    m_pending = 1'b0;
    @(posedge clk); #1;
    check("post_rst_tready", DW'(axis_in_tready), DW'(1));
  endtask

  initial begin
    time t_first;
    int  kind;
    int  n;

    resetn         = 1'b0;
    row_ready      = 1'b0;
    axis_in_tvalid = 1'b0;
    axis_in_tdata  = '0;
    axis_in_tuser  = 1'b0;
    axis_in_tlast  = 1'b0;
    gap_en         = 1'b0;
    m_in = 1'b0; m_err = 0; m_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Good frame, then a back-to-back frame to measure the row period
    send_row(32'h0000_0123, ENTRIES, 1'b1, 1'b0, 32'h1000);
    t_first = t_hdr;
    check("good_first_entry", DW'(row_data0[31:0]), DW'(32'h1000));
    check("good_last_entry", DW'(row_data3[511:480]), DW'(32'h103F));
    check("good_index", DW'(row_index), DW'(32'h123));
    deliver(0);
    send_row(32'h0000_0456, ENTRIES, 1'b1, 1'b1, 32'h0);
    check("row_period", DW'(t_hdr - t_first), DW'(66 * 10));
    deliver(0);

    // Backpressure
    send_row(32'h0000_0ABC, ENTRIES, 1'b1, 1'b1, 32'h0);
    deliver(10);

    // Short frame (tlast on entry 40), then a good frame
    send_row(32'h0000_0077, 41, 1'b1, 1'b1, 32'h0);
    gap();
    check("short_no_valid", DW'(row_valid), DW'(0));
    send_row(32'h0000_0007, ENTRIES, 1'b1, 1'b0, 32'h2000);
    deliver(2);

    // Restart mid-frame
    send_row(32'h0000_0005, 20, 1'b0, 1'b1, 32'h0);
    send_row(32'h0000_0009, ENTRIES, 1'b1, 1'b1, 32'h0);
    deliver(1);

    // Stray data beats after a fresh reset
    do_reset();
    for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0, 1'b0);
    gap(); gap();
    check("stray_err_count", DW'(err_count), DW'(exp_cnt(3)));

    // Long frame: no tlast on the last slot, trailing beats become stray
    send_row(32'h0000_0033, ENTRIES + 2, 1'b0, 1'b1, 32'h0);
    gap(); gap();
    check("long_err_count", DW'(err_count), DW'(exp_cnt(m_err)));

    // Reset at entry 30, then a full frame with no error counted
    send_row(32'h0000_0044, 30, 1'b0, 1'b1, 32'h0);
    do_reset();
    send_row(32'h0000_0055, ENTRIES, 1'b1, 1'b1, 32'h0);
    deliver(1);
    check("post_rst_err_count", DW'(err_count), DW'(0));

    // Reset while a row is pending
    send_row(32'h0000_0066, ENTRIES, 1'b1, 1'b1, 32'h0);
    do_reset();

    // Randomized frames of all kinds with random gaps and delivery stalls
    gap_en = 1'b1;
    for (int f = 0; f < 14; f++) begin
      kind = int'($urandom_range(3));
      case (kind)
        0, 1: send_row($urandom, ENTRIES, 1'b1, 1'b1, 32'h0);
        2:    begin n = int'($urandom_range(1, ENTRIES - 1)); send_row($urandom, n, 1'b1, 1'b1, 32'h0); end
        default: begin n = int'($urandom_range(1, ENTRIES + 2)); send_row($urandom, n, 1'b0, 1'b1, 32'h0); end
      endcase
      if (m_pending) deliver(int'($urandom_range(0, 4)));
    end
    gap_en = 1'b0;
    gap(); gap();
    check("final_err_count", DW'(err_count), DW'(exp_cnt(m_err)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
